// File: rtl/cond_eval_arbiter.sv
// Round-robin arbiter sharing one sign/zero condition evaluator among NUM_REQ requesters.
// Optional statistics counters are enabled by defining COND_ARB_STATS_EN.
module cond_eval_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ID_W    = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]   req_num_i,
  input  logic [NUM_REQ*3-1:0]       req_cond_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [ID_W-1:0]            rsp_id_o,
  output logic                       rsp_taken_o,
  output logic                       rsp_lt0_o,
  output logic                       rsp_eq0_o
`ifdef COND_ARB_STATS_EN
  ,
  output logic [15:0]                stat_evals_o,
  output logic [15:0]                stat_taken_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  num_q;
  logic [2:0]        cond_q;

  logic              found;
  int unsigned       win_int;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   ptr_d;
  logic              eval_lt;
  logic              eval_eq;
  logic              eval_gt;
  logic              eval_taken;

  // Round-robin scan starting at ptr_q; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_int = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found   = 1'b1;
        win_int = idx;
      end
    end
    win_id = ID_W'(win_int);
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && found) req_ready_o[win_int] = 1'b1;
  end

  always_comb begin
    eval_lt    = num_q[WIDTH-1];
    eval_eq    = (num_q == '0);
    eval_gt    = ~eval_lt & ~eval_eq;
    eval_taken = |(cond_q & {eval_lt, eval_eq, eval_gt});
    ptr_d      = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      num_q       <= '0;
      cond_q      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_taken_o <= 1'b0;
      rsp_lt0_o   <= 1'b0;
      rsp_eq0_o   <= 1'b0;
`ifdef COND_ARB_STATS_EN
      stat_evals_o <= '0;
      stat_taken_o <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            num_q   <= req_num_i[win_int*WIDTH +: WIDTH];
            cond_q  <= req_cond_i[win_int*3 +: 3];
            id_q    <= win_id;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          rsp_valid_o <= 1'b1;
          rsp_id_o    <= id_q;
          rsp_taken_o <= eval_taken;
          rsp_lt0_o   <= eval_lt;
          rsp_eq0_o   <= eval_eq;
`ifdef COND_ARB_STATS_EN
          stat_evals_o <= stat_evals_o + 16'd1;
          if (eval_taken) stat_taken_o <= stat_taken_o + 16'd1;
`endif
          state_q     <= S_RESP;
        end
        S_RESP: begin
          // Response fields hold until consumed; pointer advances past the served id.
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
